// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, mult/div EX sequencing.
// Optional HAZARD_STATS_EN adds a saturating stall-cycle counter output (stall_cnt).
//
// state   | meaning
// IDLE    | no mult/div in progress; ex_md_start launches one
// MD_BUSY | mult/div occupying EX; cnt counts remaining stall cycles
module hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic              id_branch_tk,
  input  logic [4:0]        ex_rs,
  input  logic [4:0]        ex_rt,
  input  logic [4:0]        ex_rd,
  input  logic              ex_memread,
  input  logic              ex_md_start,
  input  logic [4:0]        mem_rd,
  input  logic              mem_regwrite,
  input  logic [4:0]        wb_rd,
  input  logic              wb_regwrite,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              idex_we,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              exmem_bubble,
  output logic              md_busy,
`ifdef HAZARD_STATS_EN
  output logic [STAT_W-1:0] stall_cnt,
`endif
  output logic              md_done
);

  localparam int CW = $clog2(MD_LATENCY);

  typedef enum logic {IDLE, MD_BUSY} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          md_stall, md_fin, lu;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] m_rd, input logic m_we,
                                         input logic [4:0] w_rd, input logic w_we);
    if (m_we && m_rd != 5'd0 && m_rd == src)      fwd_sel = 2'b10;
    else if (w_we && w_rd != 5'd0 && w_rd == src) fwd_sel = 2'b01;
    else                                          fwd_sel = 2'b00;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    md_stall = 1'b0;
    md_fin   = 1'b0;
    case (state)
      IDLE: begin
        if (ex_md_start) begin
          md_stall = 1'b1;
          state_nx = MD_BUSY;
          cnt_nx   = CW'(MD_LATENCY - 2);
        end
      end
      MD_BUSY: begin
        if (cnt != '0) begin
          md_stall = 1'b1;
          cnt_nx   = cnt - CW'(1);
        end else begin
          md_fin   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign lu = ex_memread && (ex_rd != 5'd0) &&
              ((ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));

  always_comb begin
    fwd_a        = 2'b00;
    fwd_b        = 2'b00;
    pc_we        = 1'b0;
    ifid_we      = 1'b0;
    idex_we      = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b1;
    exmem_bubble = 1'b1;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    if (!reset) begin
      fwd_a        = fwd_sel(ex_rs, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
      fwd_b        = fwd_sel(ex_rt, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
      md_busy      = (state == MD_BUSY);
      md_done      = md_fin;
      // mult/div stall holds ID/EX, so a coincident load-use inserts no bubble
      pc_we        = !(md_stall || lu);
      ifid_we      = !(md_stall || lu);
      idex_we      = !md_stall;
      idex_bubble  = lu && !md_stall;
      exmem_bubble = md_stall;
      ifid_flush   = id_branch_tk && !md_stall && !lu;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (!pc_we && stall_cnt != '1)
      stall_cnt <= stall_cnt + STAT_W'(1);
  end
`endif

endmodule
